// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl
// Initiator side of the register file port set. Writebacks are buffered in a
// small FIFO and drained one per cycle into the register file. Operand reads
// return a registered response one cycle after acceptance.
// Build option: REGFILE_BYPASS_EN
//   defined     - pending writebacks forward to operand reads, reads never stall
//   not defined - a read stalls while a pending writeback targets one of its
//                 nonzero sources, then takes register file data
module regfile_access_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wb_valid,
    output logic                   wb_ready,
    input  logic [AW-1:0]          wb_rd,
    input  logic [DW-1:0]          wb_data,
    input  logic                   rd_req_valid,
    output logic                   rd_req_ready,
    input  logic [AW-1:0]          rd_rs1,
    input  logic [AW-1:0]          rd_rs2,
    output logic                   rd_rsp_valid,
    output logic [DW-1:0]          rd_rsp_data1,
    output logic [DW-1:0]          rd_rsp_data2,
    output logic [AW-1:0]          rf_addr_rs1,
    output logic [AW-1:0]          rf_addr_rs2,
    output logic [AW-1:0]          rf_addr_rd,
    output logic [DW-1:0]          rf_data_rd,
    output logic                   rf_write_enable,
    input  logic [DW-1:0]          rf_data_rs1,
    input  logic [DW-1:0]          rf_data_rs2,
    output logic [$clog2(DEPTH):0] pending_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] fifo_rd   [DEPTH];
    logic [DW-1:0] fifo_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          push;
    logic          pop;
    logic          rd_acc;
    logic          hit1;
    logic          hit2;
    logic [PW-1:0] idx;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
`ifdef REGFILE_BYPASS_EN
    logic [DW-1:0] fwd1;
    logic [DW-1:0] fwd2;
`endif

    // Writes to x0 complete the handshake but are dropped; the head drains
    // every cycle the FIFO holds anything.
    assign wb_ready        = (count != CW'(DEPTH));
    assign push            = wb_valid && wb_ready && (wb_rd != '0);
    assign pop             = (count != '0);
    assign rf_write_enable = pop;
    assign rf_addr_rd      = fifo_rd[rd_ptr];
    assign rf_data_rd      = fifo_data[rd_ptr];
    assign rf_addr_rs1     = rd_rs1;
    assign rf_addr_rs2     = rd_rs2;
    assign pending_count   = count;
    assign rd_acc          = rd_req_valid && rd_req_ready;

    // FIFO storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= wb_rd;
            fifo_data[wr_ptr] <= wb_data;
        end
    end

    // Pointers and occupancy; pending entries are discarded on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Scan valid entries oldest to youngest so the last match wins. The head
    // is included: the register file commits it at this edge but reads old data.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        idx  = '0;
`ifdef REGFILE_BYPASS_EN
        fwd1 = '0;
        fwd2 = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (CW'(k) < count) begin
                if ((rd_rs1 != '0) && (fifo_rd[idx] == rd_rs1)) begin
                    hit1 = 1'b1;
`ifdef REGFILE_BYPASS_EN
                    fwd1 = fifo_data[idx];
`endif
                end
                if ((rd_rs2 != '0) && (fifo_rd[idx] == rd_rs2)) begin
                    hit2 = 1'b1;
`ifdef REGFILE_BYPASS_EN
                    fwd2 = fifo_data[idx];
`endif
                end
            end
        end
    end

    // Operand select: x0 reads zero, otherwise forwarded or register file data.
    always_comb begin
        op1 = '0;
        op2 = '0;
        if (rd_rs1 != '0) op1 = rf_data_rs1;
        if (rd_rs2 != '0) op2 = rf_data_rs2;
`ifdef REGFILE_BYPASS_EN
        if (hit1) op1 = fwd1;
        if (hit2) op2 = fwd2;
`endif
    end

`ifdef REGFILE_BYPASS_EN
    assign rd_req_ready = 1'b1;
`else
    // Hold off a read until every pending write to its sources has committed.
    assign rd_req_ready = ~(hit1 | hit2);
`endif

    // Registered operand response; data holds between responses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_rsp_valid <= 1'b0;
            rd_rsp_data1 <= '0;
            rd_rsp_data2 <= '0;
        end else begin
            rd_rsp_valid <= rd_acc;
            if (rd_acc) begin
                rd_rsp_data1 <= op1;
                rd_rsp_data2 <= op2;
            end
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: behavioural register file, architectural
// reference model, and a response scoreboard.
module tb_regfile_access_ctrl;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int NREG  = 2 ** AW;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          wb_valid = 1'b0;
    logic          wb_ready;
    logic [AW-1:0] wb_rd = '0;
    logic [DW-1:0] wb_data = '0;
    logic          rd_req_valid = 1'b0;
    logic          rd_req_ready;
    logic [AW-1:0] rd_rs1 = '0;
    logic [AW-1:0] rd_rs2 = '0;
    logic          rd_rsp_valid;
    logic [DW-1:0] rd_rsp_data1;
    logic [DW-1:0] rd_rsp_data2;
    logic [AW-1:0] rf_addr_rs1;
    logic [AW-1:0] rf_addr_rs2;
    logic [AW-1:0] rf_addr_rd;
    logic [DW-1:0] rf_data_rd;
    logic          rf_write_enable;
    logic [DW-1:0] rf_data_rs1;
    logic [DW-1:0] rf_data_rs2;
    logic [CW-1:0] pending_count;

    always #5 clock = ~clock;

    regfile_access_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clock(clock), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_rs1(rd_rs1), .rd_rs2(rd_rs2),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data1(rd_rsp_data1), .rd_rsp_data2(rd_rsp_data2),
        .rf_addr_rs1(rf_addr_rs1), .rf_addr_rs2(rf_addr_rs2), .rf_addr_rd(rf_addr_rd),
        .rf_data_rd(rf_data_rd), .rf_write_enable(rf_write_enable),
        .rf_data_rs1(rf_data_rs1), .rf_data_rs2(rf_data_rs2),
        .pending_count(pending_count)
    );

    // Register file: combinational read, write at the clock edge.
    logic [DW-1:0] rf_mem [NREG] = '{default: '0};
    always @(posedge clock) if (rf_write_enable) rf_mem[rf_addr_rd] <= rf_data_rd;
    assign rf_data_rs1 = rf_mem[rf_addr_rs1];
    assign rf_data_rs2 = rf_mem[rf_addr_rs2];

    typedef struct packed { logic [AW-1:0] rd; logic [DW-1:0] data; } wr_t;
    typedef struct packed { logic [DW-1:0] d1; logic [DW-1:0] d2; } rsp_t;

    logic [DW-1:0] arch [NREG];   // all accepted writes
    logic [DW-1:0] comm [NREG];   // writes that reached the register file
    wr_t           pend [$];
    rsp_t          sb   [$];
    bit            exp_rsp_vld = 1'b0;
    logic [DW-1:0] last_d1 = '0;
    logic [DW-1:0] last_d2 = '0;
    int            checks = 0;
    int            failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit pend_has(input logic [AW-1:0] rs);
        pend_has = 1'b0;
        if (rs != '0)
            foreach (pend[i]) if (pend[i].rd == rs) pend_has = 1'b1;
    endfunction

    // One cycle: drive at negedge, check outputs, then advance the model at posedge.
    task automatic step(input bit wv, input logic [AW-1:0] wrd, input logic [DW-1:0] wd,
                        input bit rv, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                        output bit wacc, output bit racc);
        bit   exp_wrdy;
        bit   exp_rrdy;
        rsp_t e;
        wr_t  w;
        @(negedge clock);
        wb_valid = wv; wb_rd = wrd; wb_data = wd;
        rd_req_valid = rv; rd_rs1 = r1; rd_rs2 = r2;
        #1;
        chk("rsp_valid", rd_rsp_valid, exp_rsp_vld);
        if (exp_rsp_vld && sb.size() != 0) begin
            e = sb.pop_front();
            last_d1 = e.d1;
            last_d2 = e.d2;
        end
        chk("rsp_data1", rd_rsp_data1, last_d1);
        chk("rsp_data2", rd_rsp_data2, last_d2);
        exp_wrdy = (pend.size() != DEPTH);
`ifdef REGFILE_BYPASS_EN
        exp_rrdy = 1'b1;
`else
        exp_rrdy = !(pend_has(r1) || pend_has(r2));
`endif
        chk("wb_ready", wb_ready, exp_wrdy);
        chk("rd_req_ready", rd_req_ready, exp_rrdy);
        chk("pending_count", pending_count, pend.size());
        chk("rf_write_enable", rf_write_enable, pend.size() != 0);
        if (pend.size() != 0) begin
            chk("rf_addr_rd", rf_addr_rd, pend[0].rd);
            chk("rf_data_rd", rf_data_rd, pend[0].data);
        end
        chk("rf_addr_rs1", rf_addr_rs1, r1);
        chk("rf_addr_rs2", rf_addr_rs2, r2);
        wacc = wv && exp_wrdy;
        racc = rv && exp_rrdy;
        if (racc) begin
            e.d1 = (r1 == '0) ? '0 : arch[r1];
            e.d2 = (r2 == '0) ? '0 : arch[r2];
            sb.push_back(e);
        end
        @(posedge clock);
        if (pend.size() != 0) begin
            w = pend.pop_front();
            comm[w.rd] = w.data;
        end
        if (wacc && wrd != '0) begin
            w.rd = wrd;
            w.data = wd;
            pend.push_back(w);
            arch[wrd] = wd;
        end
        exp_rsp_vld = racc;
    endtask

    // Asynchronous reset pulse mid-cycle; pending writes must be dropped.
    task automatic do_reset();
        @(negedge clock);
        wb_valid = 1'b0;
        rd_req_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_count", pending_count, 0);
        chk("rst_we", rf_write_enable, 0);
        chk("rst_rsp_valid", rd_rsp_valid, 0);
        chk("rst_rsp_data1", rd_rsp_data1, 0);
        chk("rst_rsp_data2", rd_rsp_data2, 0);
        pend.delete();
        sb.delete();
        exp_rsp_vld = 1'b0;
        last_d1 = '0;
        last_d2 = '0;
        for (int i = 0; i < NREG; i++) arch[i] = comm[i];
        @(negedge clock);
        chk("rst_hold_count", pending_count, 0);
        for (int i = 0; i < NREG; i++) chk($sformatf("rst_reg%0d", i), rf_mem[i], comm[i]);
        reset = 1'b1;
    endtask

    initial begin
        bit            wa;
        bit            ra;
        bit            hw;
        bit            hr;
        bit            wv;
        bit            rv;
        int            stalls;
        logic [AW-1:0] wrd;
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
        logic [DW-1:0] wd;

        for (int i = 0; i < NREG; i++) begin
            arch[i] = '0;
            comm[i] = '0;
        end
        do_reset();

        // T2: write x5, idle, read x5/x0
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, wa, ra);
        chk("t2_wacc", wa, 1);
        step(0, 0, 0, 0, 0, 0, wa, ra);
        step(0, 0, 0, 0, 0, 0, wa, ra);
        step(0, 0, 0, 1, 5, 0, wa, ra);
        chk("t2_racc", ra, 1);
        step(0, 0, 0, 0, 0, 0, wa, ra);
        chk("t2_data1", rd_rsp_data1, 32'hDEADBEEF);
        chk("t2_data2", rd_rsp_data2, 32'h0);

        // T5: write to x0 is accepted but never enqueued
        step(1, 0, 32'hFFFF, 0, 0, 0, wa, ra);
        chk("t5_wacc", wa, 1);
        step(0, 0, 0, 1, 0, 0, wa, ra);
        chk("t5_count", pending_count, 0);
        step(0, 0, 0, 0, 0, 0, wa, ra);
        chk("t5_data1", rd_rsp_data1, 32'h0);

        // T3: back-to-back writes; drain keeps pace
        for (int i = 1; i <= DEPTH; i++) step(1, AW'(i + 10), DW'(i * 3), 0, 0, 0, wa, ra);
        step(0, 0, 0, 0, 0, 0, wa, ra);

        // T4: two writes to x7, read must see the younger value
        step(1, 7, 32'h11, 0, 0, 0, wa, ra);
        stalls = 0;
`ifdef REGFILE_BYPASS_EN
        step(1, 7, 32'h22, 0, 0, 0, wa, ra);
        step(0, 0, 0, 1, 7, 0, wa, ra);
        chk("t4_racc", ra, 1);
`else
        step(1, 7, 32'h22, 1, 7, 0, wa, ra);
        while (!ra && stalls < 8) begin
            stalls++;
            step(0, 0, 0, 1, 7, 0, wa, ra);
        end
        chk("t4_stalls", stalls, 2);
`endif
        step(0, 0, 0, 0, 0, 0, wa, ra);
        chk("t4_data1", rd_rsp_data1, 32'h22);

        // T1: reset while writes are still pending
        step(1, 9, 32'hA1, 0, 0, 0, wa, ra);
        step(1, 10, 32'hA2, 0, 0, 0, wa, ra);
        step(1, 11, 32'hA3, 0, 0, 0, wa, ra);
        do_reset();

        // T6: random traffic, requests held until accepted
        hw = 0; hr = 0; wv = 0; rv = 0;
        wrd = '0; r1 = '0; r2 = '0; wd = '0;
        for (int c = 0; c < 10000; c++) begin
            if (!hw) begin
                wv  = ($urandom_range(0, 99) < 60);
                wrd = AW'($urandom_range(0, 7));
                wd  = DW'($urandom);
            end
            if (!hr) begin
                rv = ($urandom_range(0, 99) < 50);
                r1 = AW'($urandom_range(0, 7));
                r2 = AW'($urandom_range(0, 7));
            end
            step(wv, wrd, wd, rv, r1, r2, wa, ra);
            hw = wv && !wa;
            hr = rv && !ra;
            if (c == 5000) begin
                do_reset();
                hw = 0;
                hr = 0;
            end
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, wa, ra);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
